gddr6_writeback_engine: RTL



---
 rtl/gddr6_writeback_pkg.sv | 35 +++
 rtl/gddr6_writeback_skid_fifo.sv | 53 +++++
 rtl/gddr6_writeback_engine.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gddr6_writeback_pkg.sv
// Shared types and constants for the GDDR6 write-back engine: FSM states,
// AXI encodings and the 4 KB-aware burst length helper.
package gddr6_writeback_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AW    = 3'd1,
        S_W     = 3'd2,
        S_B     = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } wb_state_t;

    localparam logic [2:0] AXI_SIZE_32B   = 3'd5;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         BEAT_BYTES     = 32;
    localparam int         BEATS_PER_4K   = 128;

    // Beats for the next burst: limited by what is left, the burst cap and
    // the room left in the current 4 KB page (page_beat = addr[11:5]).
    function automatic logic [8:0] calc_burst_len(
        input logic [8:0]  remaining,
        input logic [6:0]  page_beat,
        input int unsigned max_burst
    );
        logic [8:0] room;
        logic [8:0] len;
        room = 9'(BEATS_PER_4K) - {2'b00, page_beat};
        len  = remaining;
        if (9'(max_burst) < len) len = 9'(max_burst);
        if (room < len)          len = room;
        return len;
    endfunction

endpackage

// File: rtl/gddr6_writeback_skid_fifo.sv
// Two-entry beat FIFO between the BRAM read port and the AXI W channel.
// The head is always held in r_head so it can drive wdata straight from a flop.
module gddr6_writeback_skid_fifo
    import gddr6_writeback_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_push,
    input  logic [BEAT_BYTES*8-1:0]   i_push_data,
    input  logic                      i_pop,
    output logic [BEAT_BYTES*8-1:0]   o_head,
    output logic [1:0]                o_count
);

    logic [BEAT_BYTES*8-1:0] r_head;
    logic [BEAT_BYTES*8-1:0] r_tail;
    logic [1:0]              r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the data flops are reset as well because r_head drives an output with a defined reset value.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_push_data;
                    else                 r_tail <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_push_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_head  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/gddr6_writeback_engine.sv
// Streams BRAM words to GDDR6 over the NAP AXI4 write channels, one burst at a time.
// Optional running checksum of written data: define GDDR6_WRITEBACK_CHECKSUM_EN.
module gddr6_writeback_engine
    import gddr6_writeback_pkg::*;
#(
    parameter int          MAX_BURST = 16,
    parameter logic [7:0]  AXI_ID    = 8'h01
) (
    input  logic         i_nap_clk,
    input  logic         i_nap_reset_n,
    input  logic         i_start,
    input  logic [27:0]  i_gddr_addr,
    input  logic [8:0]   i_bram_addr,
    input  logic [8:0]   i_length,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error,
    output logic [31:0]  o_checksum,
    output logic         o_bram_rd_en,
    output logic [8:0]   o_bram_rd_addr,
    input  logic [255:0] i_bram_rd_data,
    output logic         o_axi_awvalid,
    input  logic         i_axi_awready,
    output logic [27:0]  o_axi_awaddr,
    output logic [7:0]   o_axi_awlen,
    output logic [7:0]   o_axi_awid,
    output logic [2:0]   o_axi_awsize,
    output logic [1:0]   o_axi_awburst,
    output logic         o_axi_wvalid,
    input  logic         i_axi_wready,
    output logic [255:0] o_axi_wdata,
    output logic [31:0]  o_axi_wstrb,
    output logic         o_axi_wlast,
    input  logic         i_axi_bvalid,
    output logic         o_axi_bready,
    input  logic [1:0]   i_axi_bresp,
    input  logic [7:0]   i_axi_bid
);

    wb_state_t    r_state;
    wb_state_t    w_next_state;

    // Current burst context
    logic [27:0]  r_addr;
    logic [8:0]   r_len;
    logic [8:0]   r_rem;
    logic [8:0]   r_beats_read;
    logic [8:0]   r_beats_sent;
    logic [8:0]   r_rd_ptr;
    logic         r_rd_pending;

    // Registered outputs
    logic         r_awvalid;
    logic [27:0]  r_awaddr;
    logic [7:0]   r_awlen;
    logic         r_wvalid;
    logic         r_wlast;
    logic         r_bready;
    logic         r_rd_en;
    logic [8:0]   r_rd_addr;
    logic         r_busy;
    logic         r_done;
    logic         r_error;

    logic [1:0]   w_fifo_count;
    logic [255:0] w_fifo_head;

    logic         w_start_acc;
    logic         w_aw_hs;
    logic         w_pop;
    logic         w_push;
    logic         w_b_hs;
    logic         w_b_bad;
    logic         w_enter_aw;
    logic [27:0]  w_burst_addr;
    logic [8:0]   w_burst_rem;
    logic [8:0]   w_burst_len;
    logic [1:0]   w_count_nxt;
    logic [8:0]   w_beats_read_base;
    logic [8:0]   w_len_base;
    logic [8:0]   w_rd_ptr_base;
    logic [8:0]   w_beats_sent_nxt;
    logic         w_rd_issue;
    logic         w_unused_addr_lsbs;

    assign w_unused_addr_lsbs = ^i_gddr_addr[4:0];

    assign w_start_acc = i_start &&
                         (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERROR);
    assign w_aw_hs = r_awvalid && i_axi_awready;
    assign w_pop   = r_wvalid && i_axi_wready;
    assign w_push  = r_rd_pending;
    assign w_b_hs  = r_bready && i_axi_bvalid;
    assign w_b_bad = (i_axi_bresp != 2'b00) || (i_axi_bid != AXI_ID);

    gddr6_writeback_skid_fifo u_fifo (
        .i_clk       (i_nap_clk),
        .i_rst_n     (i_nap_reset_n),
        .i_push      (w_push),
        .i_push_data (i_bram_rd_data),
        .i_pop       (w_pop),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    always_ff @(posedge i_nap_clk or negedge i_nap_reset_n) begin
        if (!i_nap_reset_n) r_state <= S_IDLE;
        else                r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path through the case infers a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (w_start_acc) w_next_state = (i_length != 9'd0) ? S_AW : S_DONE;
            end
            S_AW: if (w_aw_hs) w_next_state = S_W;
            S_W:  if (w_pop && r_wlast) w_next_state = S_B;
            S_B: begin
                if (w_b_hs) begin
                    if (w_b_bad)              w_next_state = S_ERROR;
                    else if (r_rem == 9'd0)   w_next_state = S_DONE;
                    else                      w_next_state = S_AW;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Next-burst parameters and read/W-channel bookkeeping, all looking one edge ahead
    // so the registered outputs line up with the state they belong to.
    always_comb begin
        w_enter_aw   = (w_next_state == S_AW) && (r_state != S_AW);
        w_burst_addr = w_start_acc ? {i_gddr_addr[27:5], 5'b0_0000}
                                   : r_addr + 28'(r_len) * 28'(BEAT_BYTES);
        w_burst_rem  = w_start_acc ? i_length : r_rem;
        w_burst_len  = calc_burst_len(w_burst_rem, w_burst_addr[11:5], MAX_BURST);

        w_count_nxt       = w_fifo_count + {1'b0, w_push} - {1'b0, w_pop};
        w_beats_read_base = w_enter_aw ? 9'd0 : r_beats_read;
        w_len_base        = w_enter_aw ? w_burst_len : r_len;
        w_rd_ptr_base     = w_start_acc ? i_bram_addr : r_rd_ptr;
        w_beats_sent_nxt  = w_enter_aw ? 9'd0 : r_beats_sent + {8'd0, w_pop};

        // A new read needs a free slot for itself beyond the one already in flight.
        w_rd_issue = (w_next_state == S_AW || w_next_state == S_W) &&
                     (w_beats_read_base < w_len_base) &&
                     (({1'b0, w_count_nxt} + {2'b00, r_rd_en}) < 3'd2);
    end

    always_ff @(posedge i_nap_clk or negedge i_nap_reset_n) begin
        if (!i_nap_reset_n) begin
            r_addr       <= '0;
            r_len        <= '0;
            r_rem        <= '0;
            r_beats_read <= '0;
            r_beats_sent <= '0;
            r_rd_ptr     <= '0;
            r_rd_pending <= 1'b0;
            r_awvalid    <= 1'b0;
            r_awaddr     <= '0;
            r_awlen      <= '0;
            r_wvalid     <= 1'b0;
            r_wlast      <= 1'b0;
            r_bready     <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_rd_pending <= r_rd_en;
            r_rd_en      <= w_rd_issue;
            r_beats_read <= w_beats_read_base + {8'd0, w_rd_issue};
            if (w_rd_issue) begin
                r_rd_addr <= w_rd_ptr_base;
                r_rd_ptr  <= w_rd_ptr_base + 9'd1;
            end else if (w_start_acc) begin
                r_rd_ptr  <= i_bram_addr;
            end

            if (w_enter_aw) begin
                r_addr   <= w_burst_addr;
                r_len    <= w_burst_len;
                r_rem    <= w_burst_rem - w_burst_len;
                r_awaddr <= w_burst_addr;
                r_awlen  <= 8'(w_burst_len - 9'd1);
            end
            r_beats_sent <= w_beats_sent_nxt;

            r_awvalid <= (w_next_state == S_AW);
            r_wvalid  <= (w_next_state == S_W) && (w_count_nxt != 2'd0);
            r_wlast   <= (w_next_state == S_W) && (w_count_nxt != 2'd0) &&
                         (w_beats_sent_nxt == r_len - 9'd1);
            r_bready  <= (w_next_state == S_B);
            r_busy    <= (w_next_state == S_AW) || (w_next_state == S_W) ||
                         (w_next_state == S_B);
            r_done    <= (w_next_state == S_DONE);
            r_error   <= (w_next_state == S_ERROR);
        end
    end

`ifdef GDDR6_WRITEBACK_CHECKSUM_EN
    logic [31:0] r_checksum;
    logic [31:0] w_beat_sum;

    always_comb begin
        w_beat_sum = '0;
        for (int k = 0; k < 8; k++) w_beat_sum = w_beat_sum + w_fifo_head[32*k +: 32];
    end

    always_ff @(posedge i_nap_clk or negedge i_nap_reset_n) begin
        if (!i_nap_reset_n)   r_checksum <= '0;
        else if (w_start_acc) r_checksum <= '0;
        else if (w_pop)       r_checksum <= r_checksum + w_beat_sum;
    end

    assign o_checksum = r_checksum;
`else
    assign o_checksum = 32'd0;
`endif

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_error        = r_error;
    assign o_bram_rd_en   = r_rd_en;
    assign o_bram_rd_addr = r_rd_addr;
    assign o_axi_awvalid  = r_awvalid;
    assign o_axi_awaddr   = r_awaddr;
    assign o_axi_awlen    = r_awlen;
    assign o_axi_awid     = AXI_ID;
    assign o_axi_awsize   = AXI_SIZE_32B;
    assign o_axi_awburst  = AXI_BURST_INCR;
    assign o_axi_wvalid   = r_wvalid;
    assign o_axi_wdata    = w_fifo_head;
    assign o_axi_wstrb    = {32{1'b1}};
    assign o_axi_wlast    = r_wlast;
    assign o_axi_bready   = r_bready;

endmodule
